reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/rst_pkg.sv | 27 ++
 rtl/rst_warm_pulse.sv | 66 ++++++
 rtl/reset_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// bit positions and a small sizing helper.
package rst_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    DEBOUNCE,
    COLD_REL,
    STAGE,
    DONE
  } rst_seq_state_t;

  localparam int CAUSE_W   = 3;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_EXT = 1;
  localparam int CAUSE_PLL = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_RESET = 3'b001;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/rst_warm_pulse.sv
// Per-domain software warm-reset pulse generator. A granted request holds busy
// high for exactly WARM_CYC cycles. The request has to be seen low before it
// can fire again, so a request held longer than the pulse yields one pulse.
module rst_warm_pulse #(
  parameter int WARM_CYC = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk_ref,
  input  logic por,
  input  logic cancel,
  input  logic enable,
  input  logic req,
  output logic busy,
  output logic busy_nxt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             busy_d;
  logic             armed_q;
  logic             armed_d;

  // Next-state: cancel beats everything, a running pulse counts down, an idle armed domain may start.
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    armed_d = armed_q;
    if (cancel) begin
      cnt_d   = '0;
      busy_d  = 1'b0;
      armed_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(WARM_CYC - 1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (enable && req && armed_q) begin
      cnt_d   = '0;
      busy_d  = 1'b1;
      armed_d = 1'b0;
    end
    if (!req) begin
      armed_d = 1'b1;
    end
  end

  // Pulse state registers, cleared by power-on reset.
  always_ff @(posedge clk_ref or posedge por) begin
    if (por) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign busy     = busy_q;
  assign busy_nxt = busy_d;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces cold reset after PLL lock and external reset
// release, then releases domain resets one at a time, and afterwards serves
// per-domain software warm-reset pulses.
// Optional feature macro: RST_CAUSE_EN enables the sticky rst_cause flags;
// without it rst_cause is tied to zero and cause_clr is ignored.
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int NUM_DOM      = 4,
  parameter int DEBOUNCE_CYC = 256,
  parameter int STAGE_CYC    = 16,
  parameter int WARM_CYC     = 16
) (
  input  logic               clk_ref,
  input  logic               por,
  input  logic               rst_ext_n,
  input  logic               pll_locked,
  input  logic [NUM_DOM-1:0] sw_rst_req,
  input  logic               cause_clr,
  output logic               rst_cold_n,
  output logic [NUM_DOM-1:0] rst_dom_n,
  output logic               rst_done,
  output logic [NUM_DOM-1:0] sw_rst_busy,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, NUM_DOM * STAGE_CYC, WARM_CYC)) + 1;
  localparam int IDX_W = $clog2(NUM_DOM + 1);

  rst_seq_state_t     state_q;
  rst_seq_state_t     state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [NUM_DOM-1:0] dom_rel_q;
  logic [NUM_DOM-1:0] dom_rel_d;
  logic [NUM_DOM-1:0] rst_dom_n_q;
  logic [NUM_DOM-1:0] rst_dom_n_d;
  logic               rst_cold_n_q;
  logic               rst_cold_n_d;
  logic               rst_done_q;
  logic               rst_done_d;
  logic               ext_s1_q;
  logic               ext_s1_d;
  logic               ext_ok_q;
  logic               ext_ok_d;
  logic               restart;
  logic               warm_en;
  logic [NUM_DOM-1:0] busy_nxt;

  // Any loss of lock or external reset outside ASSERT restarts the whole sequence.
  assign restart = (state_q != ASSERT) && (!ext_ok_q || !pll_locked);
  assign warm_en = (state_q == DONE) && !restart;

  // Two-flop synchroniser for the asynchronous external reset pin.
  always_comb begin
    ext_s1_d = rst_ext_n;
    ext_ok_d = ext_s1_q;
  end

  // Sequencing FSM: debounce, cold release, staged domain release, done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dom_rel_d    = dom_rel_q;
    rst_cold_n_d = rst_cold_n_q;
    rst_done_d   = rst_done_q;
    if (restart) begin
      state_d      = ASSERT;
      cnt_d        = '0;
      idx_d        = '0;
      dom_rel_d    = '0;
      rst_cold_n_d = 1'b0;
      rst_done_d   = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          cnt_d        = '0;
          idx_d        = '0;
          dom_rel_d    = '0;
          rst_cold_n_d = 1'b0;
          rst_done_d   = 1'b0;
          if (pll_locked && ext_ok_q) begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            state_d      = COLD_REL;
            cnt_d        = '0;
            rst_cold_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        COLD_REL, STAGE: begin
          state_d = STAGE;
          if (idx_q == IDX_W'(NUM_DOM)) begin
            state_d    = DONE;
            rst_done_d = 1'b1;
          end else if (cnt_q == CNT_W'(STAGE_CYC - 1)) begin
            for (int k = 0; k < NUM_DOM; k++) begin
              if (idx_q == IDX_W'(k)) begin
                dom_rel_d[k] = 1'b1;
              end
            end
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
    rst_dom_n_d = dom_rel_d & ~busy_nxt;
  end

  // Sequencer and synchroniser registers; power-on reset forces ASSERT with all resets low.
  always_ff @(posedge clk_ref or posedge por) begin
    if (por) begin
      state_q      <= ASSERT;
      cnt_q        <= '0;
      idx_q        <= '0;
      dom_rel_q    <= '0;
      rst_dom_n_q  <= '0;
      rst_cold_n_q <= 1'b0;
      rst_done_q   <= 1'b0;
      ext_s1_q     <= 1'b0;
      ext_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dom_rel_q    <= dom_rel_d;
      rst_dom_n_q  <= rst_dom_n_d;
      rst_cold_n_q <= rst_cold_n_d;
      rst_done_q   <= rst_done_d;
      ext_s1_q     <= ext_s1_d;
      ext_ok_q     <= ext_ok_d;
    end
  end

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_warm
    rst_warm_pulse #(
      .WARM_CYC (WARM_CYC),
      .CNT_W    (CNT_W)
    ) u_warm (
      .clk_ref  (clk_ref),
      .por      (por),
      .cancel   (restart),
      .enable   (warm_en),
      .req      (sw_rst_req[i]),
      .busy     (sw_rst_busy[i]),
      .busy_nxt (busy_nxt[i])
    );
  end

`ifdef RST_CAUSE_EN
  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] cause_d;

  // Sticky cause flags; a new cause wins over a clear on the same edge.
  always_comb begin
    cause_d = cause_q;
    if (cause_clr) begin
      cause_d = '0;
    end
    if (ext_ok_q && !ext_s1_q) begin
      cause_d[CAUSE_EXT] = 1'b1;
    end
    if ((state_q != ASSERT) && !pll_locked) begin
      cause_d[CAUSE_PLL] = 1'b1;
    end
  end

  // Cause register; power-on reset records the por cause.
  always_ff @(posedge clk_ref or posedge por) begin
    if (por) begin
      cause_q <= CAUSE_RESET;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr;
  assign rst_cause        = '0;
`endif

  assign rst_cold_n = rst_cold_n_q;
  assign rst_dom_n  = rst_dom_n_q;
  assign rst_done   = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with NUM_DOM=3, DEBOUNCE_CYC=8,
// STAGE_CYC=4, WARM_CYC=4. Cause expectations follow RST_CAUSE_EN.
module tb_reset_sequencer;

`ifdef RST_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  logic       clk_ref;
  logic       por;
  logic       rst_ext_n;
  logic       pll_locked;
  logic [2:0] sw_rst_req;
  logic       cause_clr;
  logic       rst_cold_n;
  logic [2:0] rst_dom_n;
  logic       rst_done;
  logic [2:0] sw_rst_busy;
  logic [2:0] rst_cause;

  int n_checks;
  int n_fail;

  reset_sequencer #(
    .NUM_DOM      (3),
    .DEBOUNCE_CYC (8),
    .STAGE_CYC    (4),
    .WARM_CYC     (4)
  ) dut (
    .clk_ref     (clk_ref),
    .por         (por),
    .rst_ext_n   (rst_ext_n),
    .pll_locked  (pll_locked),
    .sw_rst_req  (sw_rst_req),
    .cause_clr   (cause_clr),
    .rst_cold_n  (rst_cold_n),
    .rst_dom_n   (rst_dom_n),
    .rst_done    (rst_done),
    .sw_rst_busy (sw_rst_busy),
    .rst_cause   (rst_cause)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  function automatic logic [2:0] exp_cause(input logic [2:0] v);
    return CAUSE_ON ? v : 3'b000;
  endfunction

  task automatic test_reset();
    por        = 1'b1;
    rst_ext_n  = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 3'b111;
    cause_clr  = 1'b0;
    repeat (3) step();
    n_checks++;
    if (rst_cold_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cold: got %b expected 0", rst_cold_n); end
    n_checks++;
    if (rst_dom_n !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_dom: got %b expected 000", rst_dom_n); end
    n_checks++;
    if (rst_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", rst_done); end
    n_checks++;
    if (sw_rst_busy !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 000", sw_rst_busy); end
    n_checks++;
    if (rst_cause !== exp_cause(3'b001)) begin
      n_fail++; $display("[TB] FAIL reset_cause: got %b expected %b", rst_cause, exp_cause(3'b001));
    end
    sw_rst_req = 3'b000;
  endtask

  // d = step at which DEBOUNCE is entered, counted from the call.
  task automatic test_sequence(input string tag, input int d);
    logic       e_cold;
    logic       e_done;
    logic [2:0] e_dom;
    for (int c = 1; c <= d + 23; c++) begin
      step();
      e_cold = (c >= d + 8);
      e_dom  = {c >= d + 20, c >= d + 16, c >= d + 12};
      e_done = (c >= d + 21);
      n_checks++;
      if (rst_cold_n !== e_cold) begin
        n_fail++; $display("[TB] FAIL %s_cold c=%0d: got %b expected %b", tag, c, rst_cold_n, e_cold);
      end
      n_checks++;
      if (rst_dom_n !== e_dom) begin
        n_fail++; $display("[TB] FAIL %s_dom c=%0d: got %b expected %b", tag, c, rst_dom_n, e_dom);
      end
      n_checks++;
      if (rst_done !== e_done) begin
        n_fail++; $display("[TB] FAIL %s_done c=%0d: got %b expected %b", tag, c, rst_done, e_done);
      end
    end
  endtask

  task automatic test_warm_pulse();
    logic [2:0] e_dom;
    logic [2:0] e_busy;
    sw_rst_req = 3'b010;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 6) sw_rst_req = 3'b000;
      e_dom  = (j <= 4) ? 3'b101 : 3'b111;
      e_busy = (j <= 4) ? 3'b010 : 3'b000;
      n_checks++;
      if (rst_dom_n !== e_dom) begin
        n_fail++; $display("[TB] FAIL warm_dom j=%0d: got %b expected %b", j, rst_dom_n, e_dom);
      end
      n_checks++;
      if (sw_rst_busy !== e_busy) begin
        n_fail++; $display("[TB] FAIL warm_busy j=%0d: got %b expected %b", j, sw_rst_busy, e_busy);
      end
      n_checks++;
      if ({rst_cold_n, rst_done} !== 2'b11) begin
        n_fail++; $display("[TB] FAIL warm_cold_done j=%0d: got %b expected 11", j, {rst_cold_n, rst_done});
      end
    end
  endtask

  task automatic test_ext_glitch();
    rst_ext_n = 1'b0;
    step();
    rst_ext_n = 1'b1;
    step();
    n_checks++;
    if (rst_done !== 1'b1) begin n_fail++; $display("[TB] FAIL ext_early_done: got %b expected 1", rst_done); end
    step();
    n_checks++;
    if ({rst_cold_n, rst_dom_n, rst_done} !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL ext_assert: got %b expected 00000", {rst_cold_n, rst_dom_n, rst_done});
    end
    n_checks++;
    if (rst_cause !== exp_cause(3'b011)) begin
      n_fail++; $display("[TB] FAIL ext_cause: got %b expected %b", rst_cause, exp_cause(3'b011));
    end
    test_sequence("ext_reseq", 1);
  endtask

  task automatic test_warm_vs_restart();
    sw_rst_req = 3'b001;
    pll_locked = 1'b0;
    step();
    n_checks++;
    if (sw_rst_busy !== 3'b000) begin n_fail++; $display("[TB] FAIL prio_busy: got %b expected 000", sw_rst_busy); end
    n_checks++;
    if ({rst_cold_n, rst_dom_n, rst_done} !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL prio_assert: got %b expected 00000", {rst_cold_n, rst_dom_n, rst_done});
    end
    n_checks++;
    if (rst_cause !== exp_cause(3'b111)) begin
      n_fail++; $display("[TB] FAIL prio_cause: got %b expected %b", rst_cause, exp_cause(3'b111));
    end
    step();
    sw_rst_req = 3'b000;
    pll_locked = 1'b1;
    test_sequence("prio_reseq", 1);
  endtask

  task automatic test_pll_loss();
    por = 1'b1;
    step();
    por = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 15) begin
        n_checks++;
        if (rst_dom_n !== 3'b001) begin n_fail++; $display("[TB] FAIL pll_dom0: got %b expected 001", rst_dom_n); end
      end
    end
    pll_locked = 1'b0;
    step();
    n_checks++;
    if ({rst_cold_n, rst_dom_n, rst_done} !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL pll_assert: got %b expected 00000", {rst_cold_n, rst_dom_n, rst_done});
    end
    n_checks++;
    if (rst_cause !== exp_cause(3'b101)) begin
      n_fail++; $display("[TB] FAIL pll_cause: got %b expected %b", rst_cause, exp_cause(3'b101));
    end
    pll_locked = 1'b1;
    test_sequence("pll_reseq", 1);
  endtask

  task automatic test_cause_clr();
    por = 1'b1;
    step();
    por = 1'b0;
    step();
    n_checks++;
    if (rst_cause !== exp_cause(3'b001)) begin
      n_fail++; $display("[TB] FAIL clr_before: got %b expected %b", rst_cause, exp_cause(3'b001));
    end
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    n_checks++;
    if (rst_cause !== 3'b000) begin n_fail++; $display("[TB] FAIL clr_after: got %b expected 000", rst_cause); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    $display("[TB] reset_sequencer directed test start");
    test_reset();
    por = 1'b0;
    test_sequence("cold_seq", 3);
    test_warm_pulse();
    test_ext_glitch();
    test_warm_vs_restart();
    test_pll_loss();
    test_cause_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
